i2c_target_regs: RTL and testbench

//   I2C target (responder) with an 8-bit register file, addressed by the CPU's bit-banged I2C master on P0/P1.

---
 rtl/i2c_target_regs.sv | 177 +++++++++++++++++
 tb/tb_i2c_target_regs.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_target_regs.sv
// I2C target with a 16 x 8-bit register file, auto-incrementing pointer, fabric read port and write-notify strobe.
// Latency: pad edges seen 3 clk after the pin; sda_oe moves 1 clk after a detected SCL fall; wr_stb on the 8th data SCL rise.
// Backpressure: none (no clock stretching); the I2C master paces every transfer. Option macro: I2C_TARGET_GENCALL_EN.
module i2c_target_regs #(
    parameter logic [6:0] DEV_ADDR = 7'h42,
    parameter int         NREGS    = 16,
    parameter int         PW       = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          scl_i,
    input  logic          sda_i,
    output logic          sda_oe,
    input  logic [PW-1:0] h_addr,
    output logic [7:0]    h_rdata,
    output logic          wr_stb,
    output logic [PW-1:0] wr_idx,
    output logic [7:0]    wr_data,
    output logic          busy
);

    typedef enum logic [3:0] {
        IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RACK
    } state_t;

    state_t        state;
    logic          scl_s1, scl_s2, scl_h;
    logic          sda_s1, sda_s2, sda_h;
    logic [3:0]    cnt;
    logic [7:0]    sr;
    logic          rw;
    logic [PW-1:0] ptr;
    logic [7:0]    regs [NREGS];

    logic          scl_rise, scl_fall, start_c, stop_c;
    logic [7:0]    rx_byte;
    logic          gc_hit, addr_hit;

    // Pad synchronizers plus one history stage for edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scl_s1 <= 1'b1; scl_s2 <= 1'b1; scl_h <= 1'b1;
            sda_s1 <= 1'b1; sda_s2 <= 1'b1; sda_h <= 1'b1;
        end else begin
            scl_s1 <= scl_i; scl_s2 <= scl_s1; scl_h <= scl_s2;
            sda_s1 <= sda_i; sda_s2 <= sda_s1; sda_h <= sda_s2;
        end
    end

    assign scl_rise = scl_s2 & ~scl_h;
    assign scl_fall = ~scl_s2 & scl_h;
    // SDA edges only count as START/STOP while SCL is steadily high
    assign start_c  = scl_s2 & scl_h & sda_h & ~sda_s2;
    assign stop_c   = scl_s2 & scl_h & ~sda_h & sda_s2;
    assign rx_byte  = {sr[6:0], sda_s2};

`ifdef I2C_TARGET_GENCALL_EN
    assign gc_hit   = (rx_byte[7:1] == 7'h00) && !rx_byte[0];
`else
    assign gc_hit   = 1'b0;
`endif
    assign addr_hit = (rx_byte[7:1] == DEV_ADDR) || gc_hit;

    assign h_rdata  = regs[h_addr];

    // Protocol FSM: bus conditions first, then bit capture on SCL rise, then SDA drive on SCL fall
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            sda_oe  <= 1'b0;
            busy    <= 1'b0;
            wr_stb  <= 1'b0;
            wr_idx  <= '0;
            wr_data <= '0;
            ptr     <= '0;
            cnt     <= '0;
            sr      <= '0;
            rw      <= 1'b0;
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
        end else begin
            wr_stb <= 1'b0;
            if (stop_c) begin
                state  <= IDLE;
                sda_oe <= 1'b0;
                busy   <= 1'b0;
            end else if (start_c) begin
                // ptr is deliberately kept so a repeated START can read from the pointer just written
                state  <= ADDR;
                cnt    <= '0;
                sda_oe <= 1'b0;
            end else if (scl_rise) begin
                case (state)
                    ADDR, PTR, WDATA: begin
                        sr  <= rx_byte;
                        cnt <= cnt + 4'd1;
                        if (cnt == 4'd7) begin
                            cnt <= '0;
                            if (state == ADDR) begin
                                if (addr_hit) begin
                                    state <= ADDR_ACK;
                                    rw    <= rx_byte[0];
                                    busy  <= 1'b1;
                                end else begin
                                    state <= IDLE;
                                    busy  <= 1'b0;
                                end
                            end else if (state == PTR) begin
                                ptr   <= rx_byte[PW-1:0];
                                state <= PTR_ACK;
                            end else begin
                                regs[ptr] <= rx_byte;
                                wr_stb    <= 1'b1;
                                wr_idx    <= ptr;
                                wr_data   <= rx_byte;
                                ptr       <= ptr + 1'b1;
                                state     <= WDATA_ACK;
                            end
                        end
                    end
                    RDATA: begin
                        cnt <= cnt + 4'd1;
                        if (cnt == 4'd7) ptr <= ptr + 1'b1;
                    end
                    RACK: begin
                        if (!sda_s2) begin
                            // byte is captured now; later writes cannot disturb it
                            sr    <= regs[ptr];
                            cnt   <= '0;
                            state <= RDATA;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end
                    default: ;
                endcase
            end else if (scl_fall) begin
                case (state)
                    ADDR_ACK: begin
                        if (!sda_oe) begin
                            sda_oe <= 1'b1;
                        end else if (rw) begin
                            sr     <= {regs[ptr][6:0], 1'b0};
                            sda_oe <= ~regs[ptr][7];
                            cnt    <= '0;
                            state  <= RDATA;
                        end else begin
                            sda_oe <= 1'b0;
                            cnt    <= '0;
                            state  <= PTR;
                        end
                    end
                    PTR_ACK, WDATA_ACK: begin
                        if (!sda_oe) begin
                            sda_oe <= 1'b1;
                        end else begin
                            sda_oe <= 1'b0;
                            cnt    <= '0;
                            state  <= WDATA;
                        end
                    end
                    RDATA: begin
                        if (cnt == 4'd8) begin
                            sda_oe <= 1'b0;
                            state  <= RACK;
                        end else begin
                            sda_oe <= ~sr[7];
                            sr     <= {sr[6:0], 1'b0};
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_i2c_target_regs.sv
// Directed bench: bit-banged I2C master on an open-drain SDA model, checking ACKs, reads and fabric side.
// Latency: master holds each SCL phase for HP clk, well above the target's synchronizer delay.
// Backpressure: none; the master never waits on the target, so every run ends on its own.
module tb_i2c_target_regs;

    localparam int HP = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       scl_m = 1'b1;
    logic       sda_m = 1'b1;
    logic       sda_i;
    logic       sda_oe;
    logic [3:0] h_addr = '0;
    logic [7:0] h_rdata;
    logic       wr_stb;
    logic [3:0] wr_idx;
    logic [7:0] wr_data;
    logic       busy;

    int n_chk = 0;
    int n_bad = 0;
    int stb_cnt = 0;
    int oe_cnt = 0;
    int s0, o0;
    logic [3:0] last_idx = '0;
    logic [7:0] last_data = '0;
    logic       ack;
    logic [7:0] rb;

    assign sda_i = sda_m & ~sda_oe;

    always #5 clk = ~clk;

    i2c_target_regs dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .scl_i   (scl_m),
        .sda_i   (sda_i),
        .sda_oe  (sda_oe),
        .h_addr  (h_addr),
        .h_rdata (h_rdata),
        .wr_stb  (wr_stb),
        .wr_idx  (wr_idx),
        .wr_data (wr_data),
        .busy    (busy)
    );

    // Fabric-side monitor, sampled away from the active edge
    always @(negedge clk) begin
        if (wr_stb) begin
            stb_cnt   <= stb_cnt + 1;
            last_idx  <= wr_idx;
            last_data <= wr_data;
        end
        if (sda_oe) oe_cnt <= oe_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic hp();
        repeat (HP) @(negedge clk);
    endtask

    task automatic i2c_start();
        sda_m = 1'b1; hp();
        scl_m = 1'b1; hp();
        sda_m = 1'b0; hp();
        scl_m = 1'b0; hp();
    endtask

    task automatic i2c_stop();
        sda_m = 1'b0; hp();
        scl_m = 1'b1; hp();
        sda_m = 1'b1; hp();
    endtask

    task automatic clk_bit(input logic b);
        sda_m = b;    hp();
        scl_m = 1'b1; hp();
        scl_m = 1'b0; hp();
    endtask

    task automatic write_byte(input logic [7:0] b, output logic a);
        for (int i = 7; i >= 0; i--) clk_bit(b[i]);
        sda_m = 1'b1; hp();
        scl_m = 1'b1; hp();
        a = sda_i;
        scl_m = 1'b0; hp();
    endtask

    task automatic read_byte(input logic nack, output logic [7:0] b);
        sda_m = 1'b1;
        for (int i = 7; i >= 0; i--) begin
            hp();
            scl_m = 1'b1; hp();
            b[i] = sda_i;
            scl_m = 1'b0;
        end
        hp();
        clk_bit(nack);
        sda_m = 1'b1;
    endtask

    task automatic peek(input logic [3:0] a, output logic [7:0] d);
        h_addr = a;
        @(negedge clk);
        d = h_rdata;
    endtask

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_sda_oe", sda_oe, 0);
        chk("rst_busy", busy, 0);
        chk("rst_wr_stb", wr_stb, 0);
        chk("rst_wr_idx", wr_idx, 0);
        chk("rst_wr_data", wr_data, 0);
        peek(4'd3, rb);  chk("rst_reg3", rb, 8'h00);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        // 1: single write to register 3
        s0 = stb_cnt;
        i2c_start();
        write_byte(8'h84, ack); chk("t1_addr_ack", ack, 0);
        chk("t1_busy", busy, 1);
        write_byte(8'h03, ack); chk("t1_ptr_ack", ack, 0);
        write_byte(8'hA5, ack); chk("t1_data_ack", ack, 0);
        i2c_stop();
        chk("t1_stb_count", stb_cnt - s0, 1);
        chk("t1_wr_idx", last_idx, 4'd3);
        chk("t1_wr_data", last_data, 8'hA5);
        peek(4'd3, rb);  chk("t1_reg3", rb, 8'hA5);
        chk("t1_busy_after_stop", busy, 0);

        // 2: pointer wraps from 15 to 0
        s0 = stb_cnt;
        i2c_start();
        write_byte(8'h84, ack); chk("t2_addr_ack", ack, 0);
        write_byte(8'h0F, ack);
        write_byte(8'h11, ack); chk("t2_d0_ack", ack, 0);
        write_byte(8'h22, ack); chk("t2_d1_ack", ack, 0);
        i2c_stop();
        chk("t2_stb_count", stb_cnt - s0, 2);
        chk("t2_last_idx", last_idx, 4'd0);
        peek(4'd15, rb); chk("t2_reg15", rb, 8'h11);
        peek(4'd0, rb);  chk("t2_reg0", rb, 8'h22);

        // 3: set pointer, repeated START, read two bytes
        i2c_start();
        write_byte(8'h84, ack);
        write_byte(8'h0F, ack); chk("t3_ptr_ack", ack, 0);
        i2c_start();
        write_byte(8'h85, ack); chk("t3_raddr_ack", ack, 0);
        read_byte(1'b0, rb);    chk("t3_rd0", rb, 8'h11);
        read_byte(1'b1, rb);    chk("t3_rd1", rb, 8'h22);
        chk("t3_busy_after_nack", busy, 0);
        i2c_stop();

        // 4: foreign address is ignored
        s0 = stb_cnt;
        o0 = oe_cnt;
        i2c_start();
        write_byte(8'h90, ack); chk("t4_addr_nack", ack, 1);
        write_byte(8'h02, ack); chk("t4_ptr_nack", ack, 1);
        write_byte(8'h66, ack);
        i2c_stop();
        chk("t4_oe_never", oe_cnt - o0, 0);
        chk("t4_no_stb", stb_cnt - s0, 0);
        chk("t4_busy", busy, 0);
        peek(4'd2, rb);  chk("t4_reg2", rb, 8'h00);

        // 5: reset while the target drives SDA (reading regs[1]=00 after test 3)
        i2c_start();
        write_byte(8'h85, ack); chk("t5_raddr_ack", ack, 0);
        sda_m = 1'b1;
        for (int i = 0; i < 3; i++) begin
            hp(); scl_m = 1'b1; hp(); scl_m = 1'b0;
        end
        hp();
        chk("t5_oe_driving", sda_oe, 1);
        #1 rst_n = 1'b0;
        #1 chk("t5_oe_async", sda_oe, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        peek(4'd15, rb); chk("t5_reg15_clr", rb, 8'h00);
        peek(4'd3, rb);  chk("t5_reg3_clr", rb, 8'h00);
        i2c_stop();
        i2c_start();
        write_byte(8'h84, ack); chk("t5_post_ack", ack, 0);
        write_byte(8'h02, ack);
        write_byte(8'h77, ack);
        i2c_stop();
        peek(4'd2, rb);  chk("t5_reg2", rb, 8'h77);

        // 6: general call write
        s0 = stb_cnt;
        i2c_start();
        write_byte(8'h00, ack);
`ifdef I2C_TARGET_GENCALL_EN
        chk("t6_gc_ack", ack, 0);
        write_byte(8'h01, ack);
        write_byte(8'h5A, ack);
        i2c_stop();
        peek(4'd1, rb);  chk("t6_reg1", rb, 8'h5A);
        chk("t6_stb", stb_cnt - s0, 1);
`else
        chk("t6_gc_nack", ack, 1);
        write_byte(8'h01, ack);
        write_byte(8'h5A, ack);
        i2c_stop();
        peek(4'd1, rb);  chk("t6_reg1", rb, 8'h00);
        chk("t6_stb", stb_cnt - s0, 0);
`endif

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
